// File: rtl/message_addr_gen.sv
// Chip / symbol address sequencer feeding the multi-channel message generator.
// Frames start on a UTC second boundary after time sync, then free-run on dac_valid.
module message_addr_gen #(
  parameter int PCODE_LEN     = 40920,
  parameter int PCODE_REPEATS = 10,
  parameter int MESSAGE_LEN   = 120,
  localparam int PW = $clog2(PCODE_LEN),
  localparam int MW = (MESSAGE_LEN > 1) ? $clog2(MESSAGE_LEN) : 1,
  localparam int RW = (PCODE_REPEATS > 1) ? $clog2(PCODE_REPEATS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          sys_time_sync_done,
  input  logic [5:0]    sys_utc_time_second,
  input  logic          dac_valid,
  output logic [PW-1:0] pcode_addr,
  output logic [MW-1:0] msg_addr,
  output logic [RW-1:0] rep_cnt,
  output logic          running,
  output logic          frame_start,
  output logic          symbol_start,
  output logic          sec_slip,
  output logic [1:0]    state
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_SEC = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;

  localparam logic [PW-1:0] PCODE_MAX = PW'(PCODE_LEN - 1);
  localparam logic [RW-1:0] REP_MAX   = RW'(PCODE_REPEATS - 1);
  localparam logic [MW-1:0] MSG_MAX   = MW'(MESSAGE_LEN - 1);

  logic [5:0]    sec_q;
  logic          enable_q;
  logic          sec_edge;
  logic          go;
  logic          code_wrap;
  logic          rep_wrap;
  logic          msg_wrap;
  logic [PW-1:0] pcode_nxt;
  logic [RW-1:0] rep_nxt;
  logic [MW-1:0] msg_nxt;
  logic          upd_zero;

  always_comb begin
    sec_edge  = (sys_utc_time_second != sec_q) && (state != IDLE);
    go        = enable && sys_time_sync_done;
    code_wrap = (pcode_addr == PCODE_MAX);
    rep_wrap  = code_wrap && (rep_cnt == REP_MAX);
    msg_wrap  = rep_wrap && (msg_addr == MSG_MAX);
    pcode_nxt = code_wrap ? '0 : pcode_addr + 1'b1;
    rep_nxt   = rep_cnt;
    if (rep_wrap)       rep_nxt = '0;
    else if (code_wrap) rep_nxt = rep_cnt + 1'b1;
    msg_nxt   = msg_addr;
    if (msg_wrap)       msg_nxt = '0;
    else if (rep_wrap)  msg_nxt = msg_addr + 1'b1;
    // Slip is judged on the counter values that will be visible after this edge.
    if (dac_valid) upd_zero = (pcode_nxt == '0) && (rep_nxt == '0) && (msg_nxt == '0);
    else           upd_zero = (pcode_addr == '0) && (rep_cnt == '0) && (msg_addr == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      pcode_addr   <= '0;
      msg_addr     <= '0;
      rep_cnt      <= '0;
      running      <= 1'b0;
      frame_start  <= 1'b0;
      symbol_start <= 1'b0;
      sec_slip     <= 1'b0;
      sec_q        <= '0;
      enable_q     <= 1'b0;
    end else begin
      sec_q        <= sys_utc_time_second;
      enable_q     <= enable;
      frame_start  <= 1'b0;
      symbol_start <= 1'b0;
      if (enable_q && !enable) sec_slip <= 1'b0;
      case (state)
        IDLE: begin
          pcode_addr <= '0;
          msg_addr   <= '0;
          rep_cnt    <= '0;
          running    <= 1'b0;
          if (go) state <= WAIT_SEC;
        end
        WAIT_SEC: begin
          pcode_addr <= '0;
          msg_addr   <= '0;
          rep_cnt    <= '0;
          if (!go) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (sec_edge) begin
            state        <= RUN;
            running      <= 1'b1;
            frame_start  <= 1'b1;
            symbol_start <= 1'b1;
          end
        end
        RUN: begin
          if (!go) begin
            state      <= IDLE;
            running    <= 1'b0;
            pcode_addr <= '0;
            msg_addr   <= '0;
            rep_cnt    <= '0;
          end else begin
            if (dac_valid) begin
              pcode_addr   <= pcode_nxt;
              rep_cnt      <= rep_nxt;
              msg_addr     <= msg_nxt;
              symbol_start <= rep_wrap;
              frame_start  <= msg_wrap;
            end
            if (sec_edge && !upd_zero) sec_slip <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          running    <= 1'b0;
          pcode_addr <= '0;
          msg_addr   <= '0;
          rep_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_message_addr_gen.sv
// Directed bench for message_addr_gen with a small 4-chip / 2-repeat / 3-symbol frame.
module tb_message_addr_gen;

  localparam int PL = 4;
  localparam int PR = 2;
  localparam int ML = 3;
  localparam int FRAME = PL * PR * ML;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       sys_time_sync_done;
  logic [5:0] sys_utc_time_second;
  logic       dac_valid;
  logic [1:0] pcode_addr;
  logic [1:0] msg_addr;
  logic [0:0] rep_cnt;
  logic       running;
  logic       frame_start;
  logic       symbol_start;
  logic       sec_slip;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int k = 0;

  always #5 clk = ~clk;

  message_addr_gen #(
    .PCODE_LEN(PL), .PCODE_REPEATS(PR), .MESSAGE_LEN(ML)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sys_time_sync_done(sys_time_sync_done),
    .sys_utc_time_second(sys_utc_time_second),
    .dac_valid(dac_valid), .pcode_addr(pcode_addr), .msg_addr(msg_addr),
    .rep_cnt(rep_cnt), .running(running), .frame_start(frame_start),
    .symbol_start(symbol_start), .sec_slip(sec_slip), .state(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(S_IDLE));
    chk({tag, "_pcode"}, 32'(pcode_addr), 0);
    chk({tag, "_msg"}, 32'(msg_addr), 0);
    chk({tag, "_rep"}, 32'(rep_cnt), 0);
    chk({tag, "_running"}, 32'(running), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_ss"}, 32'(symbol_start), 0);
  endtask

  // One RUN cycle; k counts valids since frame start and defines the expected counters.
  task automatic run_step(input string tag, input logic dv);
    logic exp_ss, exp_fs;
    dac_valid = dv;
    tick();
    exp_ss = 1'b0;
    exp_fs = 1'b0;
    if (dv) begin
      k = (k + 1) % FRAME;
      exp_ss = (k % (PL * PR)) == 0;
      exp_fs = (k == 0);
    end
    chk({tag, "_pcode"}, 32'(pcode_addr), k % PL);
    chk({tag, "_rep"}, 32'(rep_cnt), (k / PL) % PR);
    chk({tag, "_msg"}, 32'(msg_addr), k / (PL * PR));
    chk({tag, "_ss"}, 32'(symbol_start), 32'(exp_ss));
    chk({tag, "_fs"}, 32'(frame_start), 32'(exp_fs));
    chk({tag, "_running"}, 32'(running), 1);
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    sys_time_sync_done = 1'b0;
    sys_utc_time_second = 6'd4;
    dac_valid = 1'b0;
    repeat (3) tick();
    chk_idle("reset");
    chk("reset_slip", 32'(sec_slip), 0);

    rst = 1'b1;
    sys_utc_time_second = 6'd5;
    tick();
    chk_idle("idle_sec_change");

    enable = 1'b1;
    sys_time_sync_done = 1'b1;
    tick();
    chk("wait_state", 32'(state), 32'(S_WAIT));
    chk("wait_running", 32'(running), 0);
    dac_valid = 1'b1;
    tick();
    chk("wait_dv_ignored", 32'(pcode_addr), 0);
    chk("wait_no_pulse", 32'(frame_start), 0);

    sys_utc_time_second = 6'd6;
    tick();
    chk("start_state", 32'(state), 32'(S_RUN));
    chk("start_running", 32'(running), 1);
    chk("start_fs", 32'(frame_start), 1);
    chk("start_ss", 32'(symbol_start), 1);
    chk("start_pcode", 32'(pcode_addr), 0);
    k = 0;

    for (int i = 0; i < FRAME; i++) run_step("frame", 1'b1);
    chk("frame_end_k", 32'(k), 0);
    chk("frame_no_slip", 32'(sec_slip), 0);

    run_step("tog1", 1'b1);
    run_step("tog0a", 1'b0);
    run_step("tog0b", 1'b0);
    run_step("tog1b", 1'b1);
    chk("tog_pcode2", 32'(pcode_addr), 2);

    for (int i = 0; i < 8; i++) run_step("advance", 1'b1);
    chk("pre_drop_pcode", 32'(pcode_addr), 2);
    chk("pre_drop_msg", 32'(msg_addr), 1);

    enable = 1'b0;
    dac_valid = 1'b1;
    tick();
    chk_idle("drop_enable");

    enable = 1'b1;
    tick();
    chk("reenable_state", 32'(state), 32'(S_WAIT));
    repeat (2) tick();
    chk("reenable_held", 32'(pcode_addr), 0);
    chk("reenable_still_wait", 32'(state), 32'(S_WAIT));
    sys_utc_time_second = 6'd7;
    tick();
    chk("restart_state", 32'(state), 32'(S_RUN));
    chk("restart_fs", 32'(frame_start), 1);
    k = 0;

    for (int i = 0; i < FRAME - 1; i++) run_step("wrap_prep", 1'b1);
    sys_utc_time_second = 6'd8;
    run_step("wrap_edge", 1'b1);
    chk("wrap_edge_no_slip", 32'(sec_slip), 0);

    for (int i = 0; i < 3; i++) run_step("slip_prep", 1'b1);
    chk("slip_prep_pcode3", 32'(pcode_addr), 3);
    sys_utc_time_second = 6'd9;
    run_step("slip_edge", 1'b0);
    chk("slip_set", 32'(sec_slip), 1);
    for (int i = 0; i < 3; i++) run_step("slip_hold", 1'b1);
    chk("slip_sticky", 32'(sec_slip), 1);

    enable = 1'b0;
    tick();
    chk_idle("slip_clear_idle");
    chk("slip_cleared", 32'(sec_slip), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/message_addr_gen.md
Name: message_addr_gen

Overview:
- Timing and address sequencer that sits directly upstream of the multi-channel message generator.
- Produces the shared spreading-code chip address and message symbol address that the generator consumes.
- After UTC time sync, aligns the start of each message frame to a UTC second boundary.
- Advances one chip per DAC-valid cycle and flags frame, symbol and repeat boundaries for downstream patching and debug.

Parameters:
- PCODE_LEN, 40920, chips per spreading-code period; pcode_addr range 0..PCODE_LEN-1.
- PCODE_REPEATS, 10, code periods per message symbol.
- MESSAGE_LEN, 120, symbols per message frame; msg_addr range 0..MESSAGE_LEN-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- enable  input  1  software run enable; level-sensitive.
- sys_time_sync_done  input  1  UTC time valid.
- sys_utc_time_second  input  6  current UTC second, 0..59.
- dac_valid  input  1  DAC sample strobe; one chip advance per high cycle.
- pcode_addr  output  $clog2(PCODE_LEN)  chip address to the code ROM and channels.
- msg_addr  output  $clog2(MESSAGE_LEN)  current message symbol index.
- rep_cnt  output  max(1,$clog2(PCODE_REPEATS))  code-period index within the symbol.
- running  output  1  high while in RUN.
- frame_start  output  1  one-cycle pulse when addresses enter all-zero (frame start).
- symbol_start  output  1  one-cycle pulse when msg_addr changes or the frame starts.
- sec_slip  output  1  sticky; a second boundary arrived during RUN while not at frame start.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; pcode_addr, msg_addr and rep_cnt = 0.
  - running, frame_start, symbol_start and sec_slip = 0.
  - sec_q = 0.
- sec_q register loads sys_utc_time_second every cycle. sec_edge = (sys_utc_time_second != sec_q) and state != IDLE.
- All outputs are registered. Address outputs change only in the cycle after the qualifying dac_valid.
- States:
  - IDLE: counters held at 0, running=0. If enable && sys_time_sync_done: go to WAIT_SEC next cycle. sec_q is then valid, so no false edge occurs.
  - WAIT_SEC: counters held at 0. On sec_edge: go to RUN; set running=1 next cycle; frame_start=1 and symbol_start=1 for that one cycle. dac_valid is ignored in WAIT_SEC and on the transition cycle.
  - RUN: on each dac_valid=1 cycle:
    - If pcode_addr < PCODE_LEN-1: increment pcode_addr.
    - Else: pcode_addr=0 and rep_cnt steps.
    - If rep_cnt was PCODE_REPEATS-1: rep_cnt=0 and msg_addr steps, with symbol_start pulsed.
    - If msg_addr was MESSAGE_LEN-1: msg_addr=0, and frame_start and symbol_start are pulsed.
    - dac_valid=0 holds every counter; pulses are 0.
- Leaving RUN or WAIT_SEC: enable=0 or sys_time_sync_done=0 → IDLE next cycle. Counters clear to 0 and running=0. This takes priority over a simultaneous dac_valid or sec_edge.
- sec_slip: set when sec_edge occurs in RUN and the counters are not all zero after this cycle's update. It clears only on reset or on an enable falling edge.
- A frame wrap coinciding with sec_edge is not a slip.
- Frame length: PCODE_LEN*PCODE_REPEATS*MESSAGE_LEN dac_valid cycles. No free-running re-alignment: RUN never re-waits on second edges.
- Degenerate parameter value 1:
  - PCODE_REPEATS=1: rep_cnt stays 0; every code wrap steps msg_addr.
  - MESSAGE_LEN=1: every symbol wrap pulses frame_start.

Test Plan (PCODE_LEN=4, PCODE_REPEATS=2, MESSAGE_LEN=3 unless noted):
- Reset with rst=0 for 3 cycles → all outputs 0 and state IDLE. A second change while in IDLE produces no pulses.
- enable=1, sync_done=1, second 5→6 → running=1 one cycle after the edge, with a frame_start pulse. Continuous dac_valid then gives pcode_addr 0,1,2,3,0 and rep_cnt 0→1 on the 5th valid.
- 24 continuous dac_valid in RUN → msg_addr sequence 0,1,2,0; symbol_start every 8 valids; frame_start on the 24th, with all counters 0.
- dac_valid toggled 1,0,0,1 → pcode_addr 1,1,1,2. Counters hold while dac_valid=0.
- Drop enable at pcode_addr=2, msg_addr=1 together with dac_valid=1 → next cycle all 0 and IDLE. Re-enable: the bench waits for the next second edge before restarting.
- Second edge in RUN at pcode_addr=3 → sec_slip=1 and sticky. Scenario edge at the frame wrap → sec_slip remains 0.
